ram_burst_reader: RTL and testbench
===================================

// Module: ram_burst_reader
// PURPOSE
//  Read-side engine for the 256x64 RAM. On a start command it issues a burst of
//  sequential reads from startAddr, wrapping 255->0. It streams the returned words
//  out on a valid/ready interface, using a 2-entry buffer to absorb backpressure.
//  It sits between RAM256x64 (read port) and any downstream consumer/checker.
// PARAMETERS
//  ADDR_W   8   RAM address width (depth = 2**ADDR_W)
//  DATA_W   64  RAM word width
// PORTS
//  clock       in   1         rising-edge clock
//  resetn      in   1         asynchronous, active-low reset
//  start       in   1         1-cycle command strobe; sampled only in IDLE
//  startAddr   in   ADDR_W    first address of burst
//  burstLen    in   ADDR_W+1  words to read, 1..256; 0 = command ignored
//  busy        out  1         high from the cycle after accepted start until done
//  done        out  1         1-cycle pulse when last word accepted downstream
//  ramAddr     out  ADDR_W    RAM read address
//  ramRead     out  1         read strobe; data returns on ramRdData next cycle
//  ramRdData   in   DATA_W    RAM read data, valid 1 cycle after ramRead
//  outData     out  DATA_W    streamed word
//  outValid    out  1         outData valid
//  outReady    in   1         downstream accepts when outValid&&outReady
// BEHAVIOUR
//  Reset (resetn=0, async): state=IDLE; busy=0, done=0, ramRead=0, ramAddr=0,
//   outValid=0, outData=0, buffer empty, counters 0. Any burst in flight is lost.
//  FSM: IDLE -> READ on start && burstLen!=0 (latch addr, issueCnt=readCnt=burstLen).
//   READ -> DRAIN when last read issued; DRAIN -> IDLE when last word accepted,
//   with done=1 for that one cycle; busy falls in the same cycle.
//  start in READ/DRAIN is ignored; start with burstLen=0 is ignored (no done).
//  Read issue: ramRead=1 in a cycle iff state=READ and issueCnt!=0 and
//   (inflight + bufCount) < 2, where inflight = ramRead of the previous cycle.
//   After each issue, ramAddr increments modulo 2**ADDR_W (255+1=0).
//  Return: the cycle after ramRead, ramRdData is written into the 2-entry FIFO.
//   FIFO head drives outData/outValid. It is never overrun, by the credit rule above.
//  Throughput: with outReady held 1, one word per cycle.
//   First outValid appears 2 cycles after start (cycle 0 start, 1 read, 2 valid).
//  Handshake: once outValid=1, outData holds stable until it is accepted.
//   outValid never drops without acceptance.
//  Simultaneous FIFO push and pop: allowed; count is unchanged.
//  done only rises after exactly burstLen accepts; a 256-word burst is supported.
//  ramWrite of the RAM is not driven here; the top level holds it 0 while busy.
// TESTING
//  1 Preload RAM[i]=i; start addr 8'h10 len 4, outReady=1 -> outData 10,11,12,13
//    on consecutive cycles; done pulses once; busy=0 the next cycle.
//  2 Wrap: start addr 8'hFE len 4 -> ramAddr FE,FF,00,01; data RAM[FE..01] in order.
//  3 Backpressure: len 8, outReady toggled randomly/held 0 for 10 cycles -> no loss
//    or duplication; at most 2 reads are outstanding plus buffered; outData is stable while stalled.
//  4 len=256 from addr 8'h00 -> exactly 256 words, last=RAM[FF]; len=0 -> no busy/done.
//  5 Second start pulsed mid-burst -> ignored; stream identical to single burst.
//  6 resetn low mid-burst (after 3 words) -> all outputs reset asynchronously;
//    a new burst after release runs correctly from its own startAddr.

Source files
------------

// File: rtl/ram_burst_reader_if.sv
// Bundle of command, RAM read-port and output-stream signals for ram_burst_reader.
// The slave modport is the reader itself; master is whatever drives commands,
// models the RAM and consumes the stream.
interface ram_burst_reader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
);
  logic              start;
  logic [ADDR_W-1:0] startAddr;
  logic [ADDR_W:0]   burstLen;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] ramAddr;
  logic              ramRead;
  logic [DATA_W-1:0] ramRdData;
  logic [DATA_W-1:0] outData;
  logic              outValid;
  logic              outReady;

  modport master (
    output start, startAddr, burstLen, ramRdData, outReady,
    input  busy, done, ramAddr, ramRead, outData, outValid
  );

  modport slave (
    input  start, startAddr, burstLen, ramRdData, outReady,
    output busy, done, ramAddr, ramRead, outData, outValid
  );
endinterface

// File: rtl/ram_burst_reader.sv
// Burst read engine for a synchronous-read RAM: issues sequential reads with
// address wrap and streams words out through a 2-entry buffer with bypass.
module ram_burst_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
) (
  input  logic                clock,
  input  logic                resetn,
  ram_burst_reader_if.slave   bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   issue_cnt_q, issue_cnt_d;
  logic [ADDR_W:0]   read_cnt_q, read_cnt_d;
  logic              done_q, done_d;
  logic              inflight_q;

  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q, count_d;

  logic              fifo_empty;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              accept;
  logic              push;
  logic              pop;
  logic              ram_read;

  // With the buffer empty the word returning from the RAM goes straight to the
  // output, giving start-to-valid latency of two cycles.
  assign fifo_empty = (count_q == 2'd0);
  assign out_valid  = !fifo_empty || inflight_q;
  assign out_data   = !fifo_empty ? fifo_mem[rd_ptr_q]
                    : (inflight_q ? bus.ramRdData : '0);
  assign accept     = out_valid && bus.outReady;
  assign push       = inflight_q && !(fifo_empty && bus.outReady);
  assign pop        = accept && !fifo_empty;

  // Credit: a read in flight plus buffered words may never exceed the 2 slots.
  assign ram_read = (state_q == ST_READ) && (issue_cnt_q != '0) &&
                    (({1'b0, inflight_q} + count_q) < 2'd2);

  assign count_d = count_q + {1'b0, push} - {1'b0, pop};

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d     = state_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    read_cnt_d  = read_cnt_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && (bus.burstLen != '0)) begin
          state_d     = ST_READ;
          addr_d      = bus.startAddr;
          issue_cnt_d = bus.burstLen;
          read_cnt_d  = bus.burstLen;
        end
      end
      ST_READ: begin
        if (ram_read) begin
          addr_d      = addr_q + 1'b1;
          issue_cnt_d = issue_cnt_q - 1'b1;
          if (issue_cnt_q == CNT_ONE) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: ;
      default: state_d = ST_IDLE;
    endcase

    // The final accept always lands in DRAIN: the last read returns a cycle
    // after it is issued, by which time the state has already moved on.
    if (accept && (state_q != ST_IDLE)) begin
      read_cnt_d = read_cnt_q - 1'b1;
      if (read_cnt_q == CNT_ONE) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples values from before the edge regardless of block ordering.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      read_cnt_q  <= '0;
      done_q      <= 1'b0;
      inflight_q  <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      read_cnt_q  <= read_cnt_d;
      done_q      <= done_d;
      inflight_q  <= ram_read;
      count_q     <= count_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // NOTE: buffer storage is not reset; count_q qualifies every read of it, so
  // stale contents are never visible and the array maps to plain registers.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.ramRdData;
  end

  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = done_q;
  assign bus.ramAddr  = addr_q;
  assign bus.ramRead  = ram_read;
  assign bus.outData  = out_data;
  assign bus.outValid = out_valid;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Self-checking bench for ram_burst_reader: RAM model, stream scoreboard,
// table of bursts plus hand sequences for latency and mid-burst reset.
module tb_ram_burst_reader;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 64;

  typedef struct {
    logic [7:0] addr;
    logic [8:0] len;
    int         mode;       // 0: ready=1, 1: random ready, 2: ready held 0 early
    bit         extra;      // pulse a second start mid-burst
    int         exp_words;
  } vec_t;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  ram_burst_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_burst_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];
  logic [7:0]  exp_addr = 8'h00;
  int          outstanding = 0;
  int          done_cnt = 0;
  int          acc_cnt = 0;
  int          busy_seen = 0;
  logic        stall_prev = 1'b0;
  logic [63:0] prev_data = '0;

  function automatic logic [63:0] ram_word(input logic [7:0] a);
    return {56'hA5A5_0000_0000_00, a};
  endfunction

  function automatic logic ready_for(input int mode, input int c);
    if (mode == 1) return 1'($urandom_range(0, 1));
    if (mode == 2) return (c >= 12);
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Synchronous-read RAM model
  always @(posedge clock) begin
    if (bus.ramRead) bus.ramRdData <= ram_word(bus.ramAddr);
  end

  // Output monitor and scoreboard, sampled mid-cycle
  always @(negedge clock) begin
    logic [63:0] e;
    if (!resetn) begin
      outstanding = 0;
      stall_prev  = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", bus.outValid, 1'b1);
        check("hold_data", bus.outData, prev_data);
      end
      if (bus.ramRead) begin
        check("credit", outstanding < 2, 1'b1);
        check("ram_addr", bus.ramAddr, exp_addr);
        exp_addr = exp_addr + 8'd1;
      end
      if (bus.outValid && bus.outReady) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_word: got %h want none", bus.outData);
        end else begin
          e = exp_q.pop_front();
          check("out_data", bus.outData, e);
        end
        acc_cnt++;
      end
      if (bus.done) begin
        done_cnt++;
        check("busy_at_done", bus.busy, 1'b0);
        check("sb_empty_at_done", exp_q.size(), 0);
      end
      if (bus.busy) busy_seen++;
      outstanding = outstanding + int'(bus.ramRead) - int'(bus.outValid && bus.outReady);
      stall_prev  = bus.outValid && !bus.outReady;
      prev_data   = bus.outData;
    end
  end

  task automatic run_burst(input vec_t v);
    int d0, b0, a0, c, budget;
    d0 = done_cnt;
    b0 = busy_seen;
    a0 = acc_cnt;
    budget = (v.exp_words == 0) ? 8 : 3000;
    @(posedge clock); #1;
    bus.start     = 1'b1;
    bus.startAddr = v.addr;
    bus.burstLen  = v.len;
    exp_addr      = v.addr;
    for (int k = 0; k < v.exp_words; k++) exp_q.push_back(ram_word(8'(v.addr + k)));
    bus.outReady = ready_for(v.mode, 0);
    c = 1;
    @(posedge clock); #1;
    while (c < budget && done_cnt == d0) begin
      bus.start = v.extra && (c == 3);
      if (v.extra && c == 3) begin
        bus.startAddr = 8'h90;
        bus.burstLen  = 9'd5;
      end
      bus.outReady = ready_for(v.mode, c);
      c++;
      @(posedge clock); #1;
    end
    if (v.mode == 0 && v.exp_words != 0) check("burst_cycles", c, v.exp_words + 3);
    bus.start    = 1'b0;
    bus.outReady = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check("done_pulses", done_cnt - d0, (v.exp_words != 0) ? 1 : 0);
    check("words", acc_cnt - a0, v.exp_words);
    check("busy_seen", busy_seen != b0, v.exp_words != 0);
    check("sb_left", exp_q.size(), 0);
    check("idle_after", bus.busy, 1'b0);
    exp_q.delete();
  endtask

  initial begin
    vec_t vecs[8];
    int   d0, a0;
    vecs[0] = '{addr: 8'h10, len: 9'd4,   mode: 0, extra: 1'b0, exp_words: 4};
    vecs[1] = '{addr: 8'hFE, len: 9'd4,   mode: 0, extra: 1'b0, exp_words: 4};
    vecs[2] = '{addr: 8'h30, len: 9'd8,   mode: 1, extra: 1'b0, exp_words: 8};
    vecs[3] = '{addr: 8'h80, len: 9'd8,   mode: 2, extra: 1'b0, exp_words: 8};
    vecs[4] = '{addr: 8'h00, len: 9'd256, mode: 0, extra: 1'b0, exp_words: 256};
    vecs[5] = '{addr: 8'h55, len: 9'd0,   mode: 0, extra: 1'b0, exp_words: 0};
    vecs[6] = '{addr: 8'h20, len: 9'd8,   mode: 0, extra: 1'b1, exp_words: 8};
    vecs[7] = '{addr: 8'hFF, len: 9'd1,   mode: 1, extra: 1'b0, exp_words: 1};

    bus.start     = 1'b0;
    bus.startAddr = '0;
    bus.burstLen  = '0;
    bus.outReady  = 1'b0;

    #12;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_ramread", bus.ramRead, 1'b0);
    check("rst_ramaddr", bus.ramAddr, 8'h00);
    check("rst_outvalid", bus.outValid, 1'b0);
    check("rst_outdata", bus.outData, 64'h0);
    @(posedge clock); #1;
    resetn = 1'b1;

    // Start-to-valid latency: start cycle 0, read cycle 1, valid cycle 2
    d0 = done_cnt;
    @(posedge clock); #1;
    bus.start = 1'b1; bus.startAddr = 8'h10; bus.burstLen = 9'd2; bus.outReady = 1'b1;
    exp_addr = 8'h10;
    exp_q.push_back(ram_word(8'h10));
    exp_q.push_back(ram_word(8'h11));
    @(negedge clock);
    check("lat_busy_c0", bus.busy, 1'b0);
    @(posedge clock); #1;
    bus.start = 1'b0;
    @(negedge clock);
    check("lat_busy_c1", bus.busy, 1'b1);
    check("lat_read_c1", bus.ramRead, 1'b1);
    check("lat_valid_c1", bus.outValid, 1'b0);
    @(negedge clock);
    check("lat_valid_c2", bus.outValid, 1'b1);
    for (int c = 0; c < 20 && done_cnt == d0; c++) @(posedge clock);
    #1;
    check("lat_done", done_cnt - d0, 1);
    exp_q.delete();

    for (int i = 0; i < 8; i++) run_burst(vecs[i]);

    // Asynchronous reset in the middle of a burst, then a fresh burst
    a0 = acc_cnt;
    @(posedge clock); #1;
    bus.start = 1'b1; bus.startAddr = 8'h40; bus.burstLen = 9'd16; bus.outReady = 1'b1;
    exp_addr = 8'h40;
    for (int k = 0; k < 16; k++) exp_q.push_back(ram_word(8'(8'h40 + k)));
    @(posedge clock); #1;
    bus.start = 1'b0;
    for (int c = 0; c < 50 && (acc_cnt - a0) < 3; c++) begin
      @(posedge clock); #1;
    end
    check("mid_words_before_rst", (acc_cnt - a0) >= 3, 1'b1);
    @(negedge clock); #2;
    resetn = 1'b0;
    #1;
    check("arst_busy", bus.busy, 1'b0);
    check("arst_done", bus.done, 1'b0);
    check("arst_ramread", bus.ramRead, 1'b0);
    check("arst_ramaddr", bus.ramAddr, 8'h00);
    check("arst_outvalid", bus.outValid, 1'b0);
    check("arst_outdata", bus.outData, 64'h0);
    exp_q.delete();
    @(posedge clock); #1;
    @(posedge clock); #1;
    resetn = 1'b1;
    run_burst('{addr: 8'hC3, len: 9'd5, mode: 1, extra: 1'b0, exp_words: 5});

    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
